cb_filter_ctrl: RTL and testbench
=================================

Name: cb_filter_ctrl

Overview:
- Front-end sequencer for the counting bloom filter.
- Shares one filter's increment/decrement ports among NumReq requesters using round-robin arbitration with valid/ready handshakes.
- Gates increments on full and decrements on empty.
- Runs a clear sequence (clear pulse, then wait for empty) and tracks filter errors.
- Sits between the requesters (e.g. ID trackers) and the filter instance; reuses the seeding types from cb_filter_pkg.

Parameters:
- NumReq, 4, number of requesters (>=1).
- DataWidth, 32, width of the element hashed by the filter.
- IdxWidth, derived $clog2(NumReq) (min 1), grant index width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- req_valid_i  in  NumReq  requester valid
- req_ready_o  out  NumReq  requester ready (one-hot or zero)
- req_op_i  in  NumReq x cb_op_e  per-requester op (CbIncr/CbDecr)
- req_data_i  in  NumReq x DataWidth  per-requester element
- clear_req_i  in  1  request a filter clear
- clear_busy_o  out  1  clear sequence in progress
- incr_valid_o  out  1  to filter incr_valid_i
- incr_data_o  out  DataWidth  to filter incr_data_i
- decr_valid_o  out  1  to filter decr_valid_i
- decr_data_o  out  DataWidth  to filter decr_data_i
- filter_clear_o  out  1  to filter filter_clear_i
- filter_full_i  in  1  from filter
- filter_empty_i  in  1  from filter
- filter_error_i  in  1  from filter
- grant_idx_o  out  IdxWidth  index of last granted requester
- error_o  out  1  sticky filter error

Behaviour:
- Reset values: all outputs 0; rr_ptr=0; state=IDLE.
- Eligible(i) = req_valid_i[i] & state==IDLE & !clear_req_i & (op==CbIncr ? !filter_full_i : !filter_empty_i).
- Grant: lowest eligible index >= rr_ptr; otherwise wrap to the lowest eligible index overall. At most one grant per cycle.
- On grant g (same cycle, combinational):
  - req_ready_o[g]=1.
  - incr_valid_o or decr_valid_o=1, matching the op; data = req_data_i[g].
  - The other valid stays 0, and its data output is 0.
- Next edge after grant g: rr_ptr <= (g+1) mod NumReq; grant_idx_o <= g.
- Latency: 0 cycles from handshake to filter port. The filter updates full/empty at the following edge, so flags are current on the next arbitration.
- Non-eligible valid requesters wait; requesters must hold valid/op/data until ready.
- FSM:
  - IDLE: if clear_req_i, no grant this cycle -> CLEAR.
  - CLEAR: filter_clear_o=1 for exactly one cycle; no grants -> WAIT.
  - WAIT: no grants; -> IDLE when filter_empty_i=1.
- clear_busy_o = (state != IDLE), registered from state.
- clear_req_i while in CLEAR/WAIT is ignored (not queued).
- Clear has priority over requests in the same cycle.
- error_o: set at the edge after filter_error_i=1. Cleared only by reset or on WAIT->IDLE. A set in the same cycle as the clear-complete wins.
- rst_i mid-clear: returns to IDLE immediately; filter_clear_o=0 the next cycle.
- NumReq=1: rr_ptr is constant 0.

Optional Feature:
- Macro CB_FILTER_CTRL_STATS_EN.
- Defined: adds ports incr_cnt_o and decr_cnt_o (32 bits each).
  - Each counts granted ops and saturates at 2^32-1.
  - Both reset to 0 on rst_i and on entry to CLEAR.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- cb_filter_pkg gains:
  - typedef enum logic {CbIncr, CbDecr} cb_op_e.
  - typedef enum logic [1:0] {CbCtrlIdle, CbCtrlClear, CbCtrlWait} cb_ctrl_state_e.
- Sub-module cb_filter_rr_pick: combinational eligible-mask + pointer -> one-hot grant, index, valid.

Test Plan:
- Four requesters all CbIncr, data 0x10..0x13, full=0 -> grants 0,1,2,3,0 in consecutive cycles; incr_data_o=0x10,0x11,0x12,0x13.
- Requester 2 CbDecr with empty=1 and requester 3 CbIncr -> only 3 granted; after empty=0, requester 2 granted next cycle.
- full=1: requester 0 CbIncr and requester 1 CbDecr -> decr_valid_o=1 with data of req 1, incr_valid_o=0, req_ready_o[0]=0.
- clear_req_i pulse with req 0 valid -> no grant that cycle; filter_clear_o=1 next cycle; clear_busy_o=1 until empty=1, then grants resume.
- filter_error_i one-cycle pulse -> error_o=1 from the next cycle, holds until clear completes, then 0.
- With CB_FILTER_CTRL_STATS_EN: 5 incr + 3 decr grants -> incr_cnt_o=5, decr_cnt_o=3; both 0 after a clear.

Source files
------------

// File: rtl/cb_filter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cb_filter_pkg
// Description : Shared types for the counting bloom filter and its front-end
//               sequencer (operation codes, controller states, helpers).
// Revision    : 1.0 - initial release
// ============================================================================
package cb_filter_pkg;

    // Operation a requester asks the filter to perform on its element.
    typedef enum logic {
        CbIncr = 1'b0,
        CbDecr = 1'b1
    } cb_op_e;

    // Clear-sequencer states of the front-end controller.
    typedef enum logic [1:0] {
        CbCtrlIdle  = 2'd0,
        CbCtrlClear = 2'd1,
        CbCtrlWait  = 2'd2
    } cb_ctrl_state_e;

    // Width of the granted-op statistics counters.
    localparam int c_cnt_width = 32;

    // Index width for n requesters, never narrower than one bit.
    function automatic int cb_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cb_filter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : cb_filter_rr_pick
// Description : Round-robin picker. Chooses the lowest eligible index at or
//               above the pointer, otherwise wraps to the lowest eligible
//               index overall. Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module cb_filter_rr_pick
    import cb_filter_pkg::*;
#(
    parameter  int NUM_REQ   = 4,
    localparam int IDX_WIDTH = cb_idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   i_eligible,
    input  logic [IDX_WIDTH-1:0] i_ptr,
    output logic [NUM_REQ-1:0]   o_grant,
    output logic [IDX_WIDTH-1:0] o_idx,
    output logic                 o_valid
);

    logic                 w_hi_found;
    logic [IDX_WIDTH-1:0] w_hi_idx;
    logic                 w_lo_found;
    logic [IDX_WIDTH-1:0] w_lo_idx;

    // Scan downwards so the last hit in each class is the lowest index.
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_found = 1'b0;
        w_lo_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (i_eligible[i]) begin
                w_lo_found = 1'b1;
                w_lo_idx   = IDX_WIDTH'(i);
                if (i >= int'(i_ptr)) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = IDX_WIDTH'(i);
                end
            end
        end
    end

    // Prefer the candidate at/after the pointer; wrap otherwise.
    always_comb begin
        o_valid = w_lo_found;
        o_idx   = w_hi_found ? w_hi_idx : w_lo_idx;
        o_grant = w_lo_found ? (NUM_REQ'(1) << o_idx) : '0;
    end

endmodule
`default_nettype wire

// File: rtl/cb_filter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cb_filter_ctrl
// Description : Front-end sequencer for the counting bloom filter. Shares the
//               filter's increment/decrement ports among NUM_REQ requesters
//               via round-robin arbitration, gates increments on full and
//               decrements on empty, runs the clear sequence and keeps a
//               sticky error flag.
//               Optional macro CB_FILTER_CTRL_STATS_EN adds saturating
//               granted-op counters incr_cnt_o / decr_cnt_o.
// Revision    : 1.0 - initial release
// ============================================================================
module cb_filter_ctrl
    import cb_filter_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 32,
    localparam int IDX_WIDTH  = cb_idx_width(NUM_REQ)
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NUM_REQ-1:0]                  req_valid_i,
    output logic [NUM_REQ-1:0]                  req_ready_o,
    input  cb_op_e [NUM_REQ-1:0]                req_op_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_data_i,
    input  logic                                clear_req_i,
    output logic                                clear_busy_o,
    output logic                                incr_valid_o,
    output logic [DATA_WIDTH-1:0]               incr_data_o,
    output logic                                decr_valid_o,
    output logic [DATA_WIDTH-1:0]               decr_data_o,
    output logic                                filter_clear_o,
    input  logic                                filter_full_i,
    input  logic                                filter_empty_i,
    input  logic                                filter_error_i,
    output logic [IDX_WIDTH-1:0]                grant_idx_o,
    output logic                                error_o
`ifdef CB_FILTER_CTRL_STATS_EN
    ,
    output logic [c_cnt_width-1:0]              incr_cnt_o,
    output logic [c_cnt_width-1:0]              decr_cnt_o
`endif
);

    cb_ctrl_state_e       r_state;
    cb_ctrl_state_e       w_state_next;
    logic                 w_idle;
    logic                 w_clear_entry;
    logic                 w_clear_done;
    logic [NUM_REQ-1:0]   w_eligible;
    logic [NUM_REQ-1:0]   w_grant;
    logic [IDX_WIDTH-1:0] w_grant_idx;
    logic                 w_grant_valid;
    logic [IDX_WIDTH-1:0] w_rr_ptr;
    cb_op_e               w_grant_op;
    logic                 w_incr_fire;
    logic                 w_decr_fire;
    logic                 r_clear_busy;
    logic                 r_error;
    logic [IDX_WIDTH-1:0] r_grant_idx;

    assign w_idle        = (r_state == CbCtrlIdle);
    assign w_clear_entry = w_idle && clear_req_i;
    assign w_clear_done  = (r_state == CbCtrlWait) && filter_empty_i;

    // Eligibility: idle, no clear pending, and the op's gating flag clear.
    always_comb begin
        w_eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_eligible[i] = req_valid_i[i] && w_idle && !clear_req_i &&
                            ((req_op_i[i] == CbIncr) ? !filter_full_i : !filter_empty_i);
        end
    end

    cb_filter_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .i_eligible (w_eligible),
        .i_ptr      (w_rr_ptr),
        .o_grant    (w_grant),
        .o_idx      (w_grant_idx),
        .o_valid    (w_grant_valid)
    );

    // Route the granted requester straight onto the matching filter port.
    always_comb begin
        w_grant_op   = req_op_i[w_grant_idx];
        w_incr_fire  = w_grant_valid && (w_grant_op == CbIncr);
        w_decr_fire  = w_grant_valid && (w_grant_op == CbDecr);
        req_ready_o  = w_grant;
        incr_valid_o = w_incr_fire;
        decr_valid_o = w_decr_fire;
        incr_data_o  = w_incr_fire ? req_data_i[w_grant_idx] : '0;
        decr_data_o  = w_decr_fire ? req_data_i[w_grant_idx] : '0;
    end

    // Round-robin pointer; a single requester needs no pointer state.
    generate
        if (NUM_REQ == 1) begin : g_ptr_single
            assign w_rr_ptr = '0;
        end else begin : g_ptr_multi
            logic [IDX_WIDTH-1:0] r_rr_ptr;
            // Advance to the slot after the winner on every grant.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_rr_ptr <= '0;
                end else if (w_grant_valid) begin
                    r_rr_ptr <= (w_grant_idx == IDX_WIDTH'(NUM_REQ - 1)) ?
                                '0 : w_grant_idx + IDX_WIDTH'(1);
                end
            end
            assign w_rr_ptr = r_rr_ptr;
        end
    endgenerate

    // Clear-sequencer state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= CbCtrlIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Clear-sequencer next state: one-cycle clear pulse, then wait for empty.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            CbCtrlIdle:  if (clear_req_i)    w_state_next = CbCtrlClear;
            CbCtrlClear:                     w_state_next = CbCtrlWait;
            CbCtrlWait:  if (filter_empty_i) w_state_next = CbCtrlIdle;
            default:                         w_state_next = CbCtrlIdle;
        endcase
    end

    assign filter_clear_o = (r_state == CbCtrlClear);

    // Busy flag, grant index and sticky error; a new error beats clear-done.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_clear_busy <= 1'b0;
            r_grant_idx  <= '0;
            r_error      <= 1'b0;
        end else begin
            r_clear_busy <= (w_state_next != CbCtrlIdle);
            if (w_grant_valid) begin
                r_grant_idx <= w_grant_idx;
            end
            if (filter_error_i) begin
                r_error <= 1'b1;
            end else if (w_clear_done) begin
                r_error <= 1'b0;
            end
        end
    end

    assign clear_busy_o = r_clear_busy;
    assign grant_idx_o  = r_grant_idx;
    assign error_o      = r_error;

`ifdef CB_FILTER_CTRL_STATS_EN
    logic [c_cnt_width-1:0] r_incr_cnt;
    logic [c_cnt_width-1:0] r_decr_cnt;

    // Saturating granted-op counters, zeroed on reset and on clear entry.
    always_ff @(posedge clk_i) begin
        if (rst_i || w_clear_entry) begin
            r_incr_cnt <= '0;
            r_decr_cnt <= '0;
        end else begin
            if (w_incr_fire && (r_incr_cnt != '1)) begin
                r_incr_cnt <= r_incr_cnt + c_cnt_width'(1);
            end
            if (w_decr_fire && (r_decr_cnt != '1)) begin
                r_decr_cnt <= r_decr_cnt + c_cnt_width'(1);
            end
        end
    end

    assign incr_cnt_o = r_incr_cnt;
    assign decr_cnt_o = r_decr_cnt;
`else
    logic w_unused_clear_entry;
    assign w_unused_clear_entry = w_clear_entry;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cb_filter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cb_filter_ctrl
// Description : Self-checking bench for cb_filter_ctrl: directed scenarios
//               followed by randomized traffic, all compared against a
//               behavioural model of arbitration, clear and error rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cb_filter_ctrl;
    import cb_filter_pkg::*;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam longint CNT_MAX = 64'hFFFF_FFFF;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [N-1:0]            req_valid;
    logic [N-1:0]            req_ready;
    cb_op_e [N-1:0]          req_op;
    logic [N-1:0][DW-1:0]    req_data;
    logic                    clear_req, clear_busy;
    logic                    incr_valid, decr_valid, filter_clear;
    logic [DW-1:0]           incr_data, decr_data;
    logic                    full, empty, ferr;
    logic [1:0]              grant_idx;
    logic                    error;
`ifdef CB_FILTER_CTRL_STATS_EN
    logic [31:0]             incr_cnt, decr_cnt;
`endif

    cb_filter_ctrl #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_op_i       (req_op),
        .req_data_i     (req_data),
        .clear_req_i    (clear_req),
        .clear_busy_o   (clear_busy),
        .incr_valid_o   (incr_valid),
        .incr_data_o    (incr_data),
        .decr_valid_o   (decr_valid),
        .decr_data_o    (decr_data),
        .filter_clear_o (filter_clear),
        .filter_full_i  (full),
        .filter_empty_i (empty),
        .filter_error_i (ferr),
        .grant_idx_o    (grant_idx),
        .error_o        (error)
`ifdef CB_FILTER_CTRL_STATS_EN
        ,
        .incr_cnt_o     (incr_cnt),
        .decr_cnt_o     (decr_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: clearing phases are "idle", "pulse pending", "waiting for empty".
    int     m_ptr = 0, m_gidx = 0, m_phase = 0;
    bit     m_err = 0;
    longint m_icnt = 0, m_dcnt = 0;
    bit     m_last_gv;
    int     m_last_g;

    logic [N-1:0]  obs_ready;
    logic          obs_iv, obs_dv, obs_fclear, obs_busy, obs_err;
    logic [DW-1:0] obs_idata, obs_ddata;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_elig(input int c);
        if (!req_valid[c] || m_phase != 0 || clear_req) return 1'b0;
        return (req_op[c] == CbIncr) ? !full : !empty;
    endfunction

    // Rotate from the pointer and take the first eligible requester.
    function automatic void m_pick(output bit gv, output int g);
        gv = 1'b0;
        g  = 0;
        for (int k = 0; k < N; k++) begin
            if (!gv && m_elig((m_ptr + k) % N)) begin
                gv = 1'b1;
                g  = (m_ptr + k) % N;
            end
        end
    endfunction

    function automatic void m_update(input bit gv, input int g);
        if (rst) begin
            m_ptr = 0; m_gidx = 0; m_phase = 0; m_err = 0; m_icnt = 0; m_dcnt = 0;
            return;
        end
        if (gv) begin
            m_ptr  = (g + 1) % N;
            m_gidx = g;
            if (req_op[g] == CbIncr) m_icnt = (m_icnt == CNT_MAX) ? CNT_MAX : m_icnt + 1;
            else                     m_dcnt = (m_dcnt == CNT_MAX) ? CNT_MAX : m_dcnt + 1;
        end
        if (m_phase == 0 && clear_req) begin
            m_phase = 1; m_icnt = 0; m_dcnt = 0;
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else if (m_phase == 2 && empty) begin
            m_phase = 0; m_err = 0;
        end
        if (ferr) m_err = 1;
    endfunction

    // One cycle: check all outputs mid-cycle against the model, then clock.
    task automatic step();
        bit           gv;
        int           g;
        logic [N-1:0] e_ready;
        bit           e_iv, e_dv;
        #2;
        m_pick(gv, g);
        e_ready = gv ? (N'(1) << g) : '0;
        e_iv    = gv && (req_op[g] == CbIncr);
        e_dv    = gv && (req_op[g] == CbDecr);
        check("req_ready",    req_ready,    e_ready);
        check("incr_valid",   incr_valid,   e_iv);
        check("incr_data",    incr_data,    e_iv ? req_data[g] : '0);
        check("decr_valid",   decr_valid,   e_dv);
        check("decr_data",    decr_data,    e_dv ? req_data[g] : '0);
        check("filter_clear", filter_clear, m_phase == 1);
        check("clear_busy",   clear_busy,   m_phase != 0);
        check("grant_idx",    grant_idx,    m_gidx);
        check("error",        error,        m_err);
`ifdef CB_FILTER_CTRL_STATS_EN
        check("incr_cnt",     incr_cnt,     m_icnt);
        check("decr_cnt",     decr_cnt,     m_dcnt);
`endif
        obs_ready = req_ready; obs_iv = incr_valid; obs_dv = decr_valid;
        obs_idata = incr_data; obs_ddata = decr_data; obs_fclear = filter_clear;
        obs_busy  = clear_busy; obs_err = error;
        m_last_gv = gv; m_last_g = g;
        @(posedge clk);
        m_update(gv, g);
        #1;
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_op = '{default: CbIncr}; req_data = '0;
        clear_req = 1'b0; full = 1'b0; empty = 1'b0; ferr = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        step();                                   // reset values
        rst = 1'b0;

        // Four incrementers rotate 0,1,2,3,0.
        req_valid = 4'hF;
        for (int i = 0; i < N; i++) req_data[i] = DW'(32'h10 + i);
        for (int k = 0; k < 5; k++) begin
            step();
            check("rr_ready", obs_ready, N'(1) << (k % 4));
            check("rr_data",  obs_idata, 32'h10 + (k % 4));
        end

        // Decrement blocked by empty; granted once empty drops.
        req_valid = 4'b1100; req_op[2] = CbDecr; req_op[3] = CbIncr; empty = 1'b1;
        step();
        check("empty_gate", obs_ready, 4'b1000);
        req_valid = 4'b0100; empty = 1'b0;
        step();
        check("empty_release", obs_ready, 4'b0100);
        check("empty_release_dv", obs_dv, 1'b1);

        // Increment blocked by full while a decrement goes through.
        req_valid = 4'b0011; req_op[0] = CbIncr; req_op[1] = CbDecr;
        req_data[1] = 32'hABCD_0001; full = 1'b1;
        step();
        check("full_dv",    obs_dv, 1'b1);
        check("full_iv",    obs_iv, 1'b0);
        check("full_data",  obs_ddata, 32'hABCD_0001);
        check("full_ready", obs_ready, 4'b0010);

        // Clear sequence with a pending requester, plus sticky error.
        full = 1'b0; req_valid = 4'b0001; ferr = 1'b1;
        step();
        ferr = 1'b0; clear_req = 1'b1;
        step();
        check("clr_nogrant", obs_ready, 4'b0000);
        check("err_set",     obs_err, 1'b1);
        clear_req = 1'b0;
        step();
        check("clr_pulse", obs_fclear, 1'b1);
        check("clr_busy",  obs_busy, 1'b1);
        step();
        check("clr_pulse_once", obs_fclear, 1'b0);
        check("err_hold", obs_err, 1'b1);
        empty = 1'b1;
        step();
        check("wait_nogrant", obs_ready, 4'b0000);
        step();
        check("clr_done_busy", obs_busy, 1'b0);
        check("clr_done_err",  obs_err, 1'b0);
        check("clr_resume",    obs_ready, 4'b0001);

        // Reset in the middle of a clear.
        req_valid = '0; empty = 1'b0; clear_req = 1'b1;
        step();
        clear_req = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        check("rst_mid_clear", obs_fclear, 1'b0);
        check("rst_mid_busy",  obs_busy, 1'b0);

`ifdef CB_FILTER_CTRL_STATS_EN
        req_valid = 4'b0001; req_op[0] = CbIncr;
        for (int k = 0; k < 5; k++) step();
        req_op[0] = CbDecr;
        for (int k = 0; k < 3; k++) step();
        req_valid = '0;
        step();
        check("stat_incr", incr_cnt, 5);
        check("stat_decr", decr_cnt, 3);
        clear_req = 1'b1;
        step();
        clear_req = 1'b0; empty = 1'b1;
        step();
        check("stat_incr_clr", incr_cnt, 0);
        check("stat_decr_clr", decr_cnt, 0);
        step();
        empty = 1'b0;
`endif

        // Randomized traffic; requesters hold until granted.
        req_valid = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || (m_last_gv && m_last_g == i)) begin
                    req_valid[i] = ($urandom_range(0, 9) < 6);
                    req_op[i]    = cb_op_e'($urandom_range(0, 1));
                    req_data[i]  = $urandom;
                end
            end
            full      = ($urandom_range(0, 3) == 0);
            empty     = ($urandom_range(0, 3) == 0);
            clear_req = ($urandom_range(0, 19) == 0);
            ferr      = ($urandom_range(0, 29) == 0);
            rst       = ($urandom_range(0, 199) == 0);
            step();
            m_last_gv = m_last_gv && !rst;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
